mac_seq: RTL

Sequencer that drives the shared `mac` datapath from a job/operand stream. It accepts a job descriptor with mode, length and saturate flag. It then consumes operand pairs over a valid/ready handshake and issues the matching clear/multiply/accumulate/saturate instruction codes to the MAC. It drains the MAC's two-deep output queue and returns the final 32-bit result over a valid/ready handshake.

---
 rtl/mac_seq_pkg.sv | 54 +++++
 rtl/mac_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the MAC sequencer: MAC instruction codes, the
// sequencer state encoding and the (mode, operation) -> instruction mapping.
// Optional feature macro: MAC_SEQ_SAT_EN (adds the SAT state).
// -----------------------------------------------------------------------------
package mac_seq_pkg;

    // MAC instruction codes: bit 2 selects dual 8x8 mode, bits 1:0 the operation.
    localparam logic [2:0] CLR16 = 3'b000;
    localparam logic [2:0] MUL16 = 3'b001;
    localparam logic [2:0] MAC16 = 3'b010;
    localparam logic [2:0] SAT16 = 3'b011;
    localparam logic [2:0] CLR8  = 3'b100;
    localparam logic [2:0] MUL8  = 3'b101;
    localparam logic [2:0] MAC8  = 3'b110;
    localparam logic [2:0] SAT8  = 3'b111;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_SAT = 2'b11
    } mac_op_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLEAR   = 4'd1,
        ST_FIRST   = 4'd2,
        ST_ACCUM   = 4'd3,
        ST_DRAIN1  = 4'd5,
        ST_DRAIN2  = 4'd6,
        ST_CAPTURE = 4'd7,
        ST_HOLD    = 4'd8
`ifdef MAC_SEQ_SAT_EN
        ,
        ST_SAT     = 4'd4
`endif
    } state_e;

    // Map a job mode (0 = 16x16, 1 = dual 8x8) and an operation to a MAC code.
    function automatic logic [2:0] mac_code(input logic mode, input mac_op_e op);
        logic [2:0] code;
        case (op)
            OP_CLR:  code = mode ? CLR8 : CLR16;
            OP_MUL:  code = mode ? MUL8 : MUL16;
            OP_MAC:  code = mode ? MAC8 : MAC16;
            OP_SAT:  code = mode ? SAT8 : SAT16;
            default: code = CLR16;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq
// Sequencer that accepts a job descriptor (mode, length, saturate), consumes
// operand pairs over valid/ready, issues clear/multiply/accumulate/saturate
// codes to the shared MAC, waits out the MAC's output queue and returns the
// final 32-bit result over valid/ready.
//
// Optional feature macro: MAC_SEQ_SAT_EN -- when defined job_sat is honoured
// and a SAT step follows the last operand; otherwise job_sat is ignored.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   job_valid/job_ready   job handshake; job_mode, job_len, job_sat descriptor
//   op_valid/op_ready     operand handshake; op_multiplier, op_multiplicand
//   mac_instruction       instruction code to the MAC (registered)
//   mac_multiplier/_multiplicand  operands to the MAC (registered)
//   mac_stall             stall to the MAC, high only while holding a result
//   mac_result            result from the MAC output queue
//   res_valid/res_ready   result handshake; res_data captured result
//   busy                  high whenever not idle
//
// All outputs are registered. The MAC-facing outputs carry the instruction
// decided in the previous cycle's state; the handshake flags are loaded from
// the next state so they are valid for the whole cycle of that state.
// -----------------------------------------------------------------------------
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             job_mode,
    input  logic [LEN_W-1:0] job_len,
    input  logic             job_sat,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_multiplier,
    input  logic [15:0]      op_multiplicand,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    output logic             mac_stall,
    input  logic [31:0]      mac_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy
);

    state_e           state_r, next_state_s, exit_state_s;
    logic             mode_r;
    logic [LEN_W-1:0] len_r, count_r, count_s, count_inc_s;
    logic             job_hs_s, op_hs_s;
    logic [2:0]       instr_s;
    logic [15:0]      mul_a_s, mul_b_s;

    logic             job_ready_r, op_ready_r, mac_stall_r, res_valid_r, busy_r;
    logic [2:0]       mac_instruction_r;
    logic [15:0]      mac_multiplier_r, mac_multiplicand_r;
    logic [31:0]      res_data_r;

`ifdef MAC_SEQ_SAT_EN
    logic             sat_r;
`else
    logic             unused_job_sat_s;
    assign unused_job_sat_s = job_sat;
`endif

    // Handshakes use the registered ready flags so the port and the FSM agree.
    assign job_hs_s    = job_valid & job_ready_r;
    assign op_hs_s     = op_valid & op_ready_r;
    assign count_inc_s = count_r + {{(LEN_W-1){1'b0}}, 1'b1};

    // Destination once the final operand pair has been accepted.
    always_comb begin
`ifdef MAC_SEQ_SAT_EN
        if (sat_r) begin
            exit_state_s = ST_SAT;
        end else begin
            exit_state_s = ST_DRAIN1;
        end
`else
        exit_state_s = ST_DRAIN1;
`endif
    end

    // Next-state, beat count and the instruction to issue from the current state.
    always_comb begin
        next_state_s = state_r;
        count_s      = count_r;
        instr_s      = CLR16;
        mul_a_s      = 16'h0000;
        mul_b_s      = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (job_hs_s) begin
                    next_state_s = ST_CLEAR;
                    count_s      = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                instr_s = mac_code(mode_r, OP_CLR);
                if (len_r == '0) begin
                    next_state_s = ST_DRAIN1;
                end else begin
                    next_state_s = ST_FIRST;
                end
            end
            ST_FIRST, ST_ACCUM: begin
                if (op_hs_s) begin
                    instr_s = mac_code(mode_r, (state_r == ST_FIRST) ? OP_MUL : OP_MAC);
                    mul_a_s = op_multiplier;
                    mul_b_s = op_multiplicand;
                    count_s = count_inc_s;
                    if (count_inc_s == len_r) begin
                        next_state_s = exit_state_s;
                    end else begin
                        next_state_s = ST_ACCUM;
                    end
                end else begin
                    // A bubble before the first beat clears; later bubbles add 0*0.
                    instr_s = mac_code(mode_r, (state_r == ST_FIRST) ? OP_CLR : OP_MAC);
                end
            end
`ifdef MAC_SEQ_SAT_EN
            ST_SAT: begin
                instr_s      = mac_code(mode_r, OP_SAT);
                next_state_s = ST_DRAIN1;
            end
`endif
            ST_DRAIN1: begin
                instr_s      = mac_code(mode_r, OP_CLR);
                next_state_s = ST_DRAIN2;
            end
            ST_DRAIN2: begin
                instr_s      = mac_code(mode_r, OP_CLR);
                next_state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                instr_s      = mac_code(mode_r, OP_CLR);
                next_state_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, job descriptor latch and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            mode_r             <= 1'b0;
            len_r              <= '0;
            count_r            <= '0;
`ifdef MAC_SEQ_SAT_EN
            sat_r              <= 1'b0;
`endif
            job_ready_r        <= 1'b0;
            op_ready_r         <= 1'b0;
            mac_instruction_r  <= CLR16;
            mac_multiplier_r   <= 16'h0000;
            mac_multiplicand_r <= 16'h0000;
            mac_stall_r        <= 1'b0;
            res_valid_r        <= 1'b0;
            res_data_r         <= 32'h0000_0000;
            busy_r             <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= count_s;
            if (job_hs_s) begin
                mode_r <= job_mode;
                len_r  <= job_len;
`ifdef MAC_SEQ_SAT_EN
                sat_r  <= job_sat;
`endif
            end
            mac_instruction_r  <= instr_s;
            mac_multiplier_r   <= mul_a_s;
            mac_multiplicand_r <= mul_b_s;
            job_ready_r        <= (next_state_s == ST_IDLE);
            op_ready_r         <= (next_state_s == ST_FIRST) || (next_state_s == ST_ACCUM);
            mac_stall_r        <= (next_state_s == ST_HOLD);
            res_valid_r        <= (next_state_s == ST_HOLD);
            busy_r             <= (next_state_s != ST_IDLE);
            if (state_r == ST_CAPTURE) begin
                res_data_r <= mac_result;
            end
        end
    end

    assign job_ready        = job_ready_r;
    assign op_ready         = op_ready_r;
    assign mac_instruction  = mac_instruction_r;
    assign mac_multiplier   = mac_multiplier_r;
    assign mac_multiplicand = mac_multiplicand_r;
    assign mac_stall        = mac_stall_r;
    assign res_valid        = res_valid_r;
    assign res_data         = res_data_r;
    assign busy             = busy_r;

endmodule
